// File: rtl/muldiv_share_arbiter_pkg.sv
// ============================================================================
//  Module   : muldiv_share_arbiter_pkg
//  Brief    : Shared types for the mul/div sharing arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv_share_arbiter_pkg;

   typedef enum logic {
      ARB_OP_MUL = 1'b0,
      ARB_OP_DIV = 1'b1
   } arb_op_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_share_arbiter_rr_pick.sv
// ============================================================================
//  Module   : muldiv_share_arbiter_rr_pick
//  Brief    : Combinational round-robin pick, first request at or above ptr.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_share_arbiter_rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_pos;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_sum   = '0;
      w_pos   = '0;
      for (int off = 0; off < N; off++) begin
         // Wrap the scan position back into 0..N-1 without a modulo operator.
         w_sum = {1'b0, i_ptr} + (IW+1)'(off);
         if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
         end
         w_pos = w_sum[IW-1:0];
         if (!o_any && i_req[w_pos]) begin
            o_any          = 1'b1;
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_share_arbiter.sv
// ============================================================================
//  Module   : muldiv_share_arbiter
//  Brief    : Shares one iterative multiplier and one divider among NUM_REQ
//             requesters, one operation in flight at a time.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_share_arbiter
   import muldiv_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ-1:0]            req_op_i,
   input  logic [NUM_REQ*4*DATA_WIDTH-1:0] req_opa_i,
   input  logic [NUM_REQ*4*DATA_WIDTH-1:0] req_opb_i,
   output logic [NUM_REQ-1:0]            resp_valid_o,
   input  logic [NUM_REQ-1:0]            resp_ready_i,
   output logic [4*DATA_WIDTH-1:0]       resp_data_o,
   output logic [4*DATA_WIDTH-1:0]       unit_opa_o,
   output logic [4*DATA_WIDTH-1:0]       unit_opb_o,
   output logic                          mul_v_o,
   output logic                          div_v_o,
   input  logic                          mul_ready_i,
   input  logic                          div_ready_i,
   input  logic                          mul_v_i,
   input  logic                          div_v_i,
   input  logic [4*DATA_WIDTH-1:0]       mul_result_i,
   input  logic [4*DATA_WIDTH-1:0]       div_quot_i,
   output logic                          mul_yumi_o,
   output logic                          div_yumi_o,
   output logic                          busy_o
);

   localparam int W  = 4 * DATA_WIDTH;
   localparam int IW = idx_width(NUM_REQ);

   arb_state_t    r_state, w_state_nxt;
   arb_op_t       r_op;
   logic [IW-1:0] r_rr_ptr, r_owner;
   logic [W-1:0]  r_opa, r_opb, r_result;

   logic [NUM_REQ-1:0] w_grant;
   logic [IW-1:0]      w_gidx, w_ptr_nxt;
   logic               w_any, w_take, w_result_take, w_unit_ready, w_unit_v;
   logic [W-1:0]       w_unit_res;

   muldiv_share_arbiter_rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .i_req   (req_valid_i),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   assign w_ptr_nxt    = (w_gidx == IW'(NUM_REQ-1)) ? '0 : w_gidx + IW'(1);
   assign w_unit_ready = (r_op == ARB_OP_MUL) ? mul_ready_i  : div_ready_i;
   assign w_unit_v     = (r_op == ARB_OP_MUL) ? mul_v_i      : div_v_i;
   assign w_unit_res   = (r_op == ARB_OP_MUL) ? mul_result_i : div_quot_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ARB_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
         r_op     <= ARB_OP_MUL;
         r_opa    <= '0;
         r_opb    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_owner  <= w_gidx;
            r_rr_ptr <= w_ptr_nxt;
            r_op     <= arb_op_t'(req_op_i[w_gidx]);
            r_opa    <= req_opa_i[int'(w_gidx)*W +: W];
            r_opb    <= req_opb_i[int'(w_gidx)*W +: W];
         end
         if (w_result_take) begin
            r_result <= w_unit_res;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_take        = 1'b0;
      w_result_take = 1'b0;
      req_ready_o   = '0;
      resp_valid_o  = '0;
      mul_v_o       = 1'b0;
      div_v_o       = 1'b0;
      mul_yumi_o    = 1'b0;
      div_yumi_o    = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               req_ready_o = w_grant;
               w_take      = 1'b1;
               w_state_nxt = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            mul_v_o = (r_op == ARB_OP_MUL);
            div_v_o = (r_op == ARB_OP_DIV);
            if (w_unit_ready) begin
               w_state_nxt = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            // Only the unit that owns the in-flight op is consumed.
            if (w_unit_v) begin
               mul_yumi_o    = (r_op == ARB_OP_MUL);
               div_yumi_o    = (r_op == ARB_OP_DIV);
               w_result_take = 1'b1;
               w_state_nxt   = ARB_RESP;
            end
         end
         ARB_RESP: begin
            resp_valid_o[r_owner] = 1'b1;
            if (resp_ready_i[r_owner]) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   assign resp_data_o = r_result;
   assign unit_opa_o  = r_opa;
   assign unit_opb_o  = r_opb;
   assign busy_o      = (r_state != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_share_arbiter.sv
// ============================================================================
//  Module   : tb_muldiv_share_arbiter
//  Brief    : Self-checking bench with behavioural unit models and a
//             transaction-level reference for grants and results.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_share_arbiter;
   import muldiv_share_arbiter_pkg::*;

   localparam int N = 2;
   localparam int W = 32;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic [N-1:0]   req_valid_i, req_ready_o, req_op_i, resp_valid_o, resp_ready_i;
   logic [N*W-1:0] req_opa_i, req_opb_i;
   logic [W-1:0]   resp_data_o, unit_opa_o, unit_opb_o, mul_result_i, div_quot_i;
   logic mul_v_o, div_v_o, mul_ready_i, div_ready_i, mul_v_i, div_v_i;
   logic mul_yumi_o, div_yumi_o, busy_o;

   always #5 clk_i = ~clk_i;

   muldiv_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
      .unit_opa_o(unit_opa_o), .unit_opb_o(unit_opb_o),
      .mul_v_o(mul_v_o), .div_v_o(div_v_o),
      .mul_ready_i(mul_ready_i), .div_ready_i(div_ready_i),
      .mul_v_i(mul_v_i), .div_v_i(div_v_i),
      .mul_result_i(mul_result_i), .div_quot_i(div_quot_i),
      .mul_yumi_o(mul_yumi_o), .div_yumi_o(div_yumi_o), .busy_o(busy_o)
   );

   // Requester side
   bit           pend [N];
   logic         p_op [N];
   logic [W-1:0] p_a  [N];
   logic [W-1:0] p_b  [N];
   // Transaction model: stage 0 free, 1 op in flight, 2 response owed
   int           ptr, stage, owner_m, wait_cnt;
   logic         op_m;
   bit           issued;
   logic [W-1:0] exp_res;
   // Unit models
   bit           mul_busy, div_busy;
   int           mul_cnt, div_cnt;
   logic [W-1:0] mul_res, div_res;
   // Handshakes seen just before the coming edge
   bit           ev_grant, ev_mfire, ev_dfire, ev_myumi, ev_dyumi, ev_resp;
   int           ev_gidx;
   logic [W-1:0] ev_ua, ev_ub;
   // Knobs and observations
   int           gen_pct, lat_fix, mul_stall, resp_stall, n_mfire, n_dfire;
   bit           junk_zero, rand_bp;
   int           glog [$];
   logic [W-1:0] last_rd;
   logic [N-1:0] last_rv;
   int           checks, failures;

   function automatic logic [W-1:0] ref_result(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!op) return a * b;
      if (b == '0) return '1;
      return $signed(a) / $signed(b);
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic finish_tb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic clear_model();
      for (int k = 0; k < N; k++) pend[k] = 0;
      ptr = 0; stage = 0; owner_m = 0; wait_cnt = 0; issued = 0; op_m = 0;
      mul_busy = 0; div_busy = 0; mul_cnt = 0; div_cnt = 0;
      ev_grant = 0; ev_mfire = 0; ev_dfire = 0; ev_myumi = 0; ev_dyumi = 0; ev_resp = 0;
      req_valid_i = '0; req_op_i = '0; req_opa_i = '0; req_opb_i = '0; resp_ready_i = '0;
      mul_ready_i = 0; div_ready_i = 0; mul_v_i = 0; div_v_i = 0;
      mul_result_i = '0; div_quot_i = '0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      clear_model();
      rst_ni = 1'b0;
      #1;
      chk("reset_outputs", {req_ready_o, resp_valid_o, mul_v_o, div_v_o, mul_yumi_o,
                            div_yumi_o, busy_o, resp_data_o, unit_opa_o, unit_opb_o}, '0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic cycle();
      logic [N-1:0] exp_rdy;
      @(negedge clk_i);
      if (ev_resp) stage = 0;
      if (ev_myumi) begin mul_busy = 0; stage = 2; end
      if (ev_dyumi) begin div_busy = 0; stage = 2; end
      if (ev_mfire) begin
         mul_busy = 1; issued = 1; n_mfire++;
         mul_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
         mul_res = ref_result(1'b0, ev_ua, ev_ub);
      end
      if (ev_dfire) begin
         div_busy = 1; issued = 1; n_dfire++;
         div_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
         div_res = ref_result(1'b1, ev_ua, ev_ub);
      end
      if (ev_grant) begin
         pend[ev_gidx] = 0;
         owner_m = ev_gidx; op_m = p_op[ev_gidx]; issued = 0;
         exp_res = ref_result(p_op[ev_gidx], p_a[ev_gidx], p_b[ev_gidx]);
         ptr = (ev_gidx + 1) % N; stage = 1; wait_cnt = 0;
         glog.push_back(ev_gidx);
      end

      // Units: busy ones count down to a held result, idle ones may raise stray valids
      if (mul_busy) begin
         if (mul_cnt == 0) mul_v_i = 1; else begin mul_cnt--; mul_v_i = 0; end
         mul_result_i = mul_v_i ? mul_res : $urandom;
      end else begin
         mul_v_i = ($urandom_range(0, 3) == 0); mul_result_i = $urandom;
      end
      if (div_busy) begin
         if (div_cnt == 0) div_v_i = 1; else begin div_cnt--; div_v_i = 0; end
         div_quot_i = div_v_i ? div_res : $urandom;
      end else begin
         div_v_i = ($urandom_range(0, 3) == 0); div_quot_i = $urandom;
      end
      mul_ready_i = !mul_busy && (mul_stall == 0) && (!rand_bp || $urandom_range(0, 2) != 0);
      div_ready_i = !div_busy && (!rand_bp || $urandom_range(0, 2) != 0);
      if (mul_stall > 0) mul_stall--;

      for (int k = 0; k < N; k++) begin
         if (!pend[k] && gen_pct > 0 && $urandom_range(1, 100) <= gen_pct) begin
            pend[k] = 1;
            p_op[k] = 1'($urandom_range(0, 1));
            p_a[k]  = $urandom_range(0, 2000) - 32'd1000;
            p_b[k]  = $urandom_range(0, 40) - 32'd20;
         end
         req_valid_i[k]        = pend[k];
         req_op_i[k]           = pend[k] ? p_op[k] : 1'($urandom);
         req_opa_i[k*W +: W]   = pend[k] ? p_a[k] : (junk_zero ? '0 : $urandom);
         req_opb_i[k*W +: W]   = pend[k] ? p_b[k] : (junk_zero ? '0 : $urandom);
      end
      if (resp_stall > 0) begin
         resp_ready_i = '0;
         if (stage == 2) resp_stall--;
      end else begin
         resp_ready_i = rand_bp ? N'($urandom) : '1;
      end

      #1;
      exp_rdy = '0; ev_grant = 0; ev_gidx = 0;
      if (stage == 0) begin
         for (int o = 0; o < N; o++) begin
            int i;
            i = (ptr + o) % N;
            if (!ev_grant && pend[i]) begin ev_grant = 1; ev_gidx = i; exp_rdy[i] = 1'b1; end
         end
      end
      chk("req_ready", req_ready_o, exp_rdy);
      chk("busy", busy_o, stage != 0);
      chk("mul_v", mul_v_o, stage == 1 && !issued && op_m == 1'b0);
      chk("div_v", div_v_o, stage == 1 && !issued && op_m == 1'b1);
      chk("mul_yumi", mul_yumi_o, mul_busy && mul_v_i);
      chk("div_yumi", div_yumi_o, div_busy && div_v_i);
      chk("resp_valid", resp_valid_o, (stage == 2) ? (N'(1) << owner_m) : N'(0));
      if (stage == 2) chk("resp_data", resp_data_o, exp_res);
      ev_myumi = mul_busy && mul_v_i;
      ev_dyumi = div_busy && div_v_i;
      ev_mfire = mul_v_o && mul_ready_i;
      ev_dfire = div_v_o && div_ready_i;
      ev_ua = unit_opa_o; ev_ub = unit_opb_o;
      ev_resp = (stage == 2) && resp_ready_i[owner_m];
      if (ev_resp) begin last_rv = resp_valid_o; last_rd = resp_data_o; end
      if (stage == 1) begin
         wait_cnt++;
         if (wait_cnt > 200) begin chk("op_timeout", 1, 0); finish_tb(); end
      end
   endtask

   task automatic run_idle();
      int n;
      bit any_pend;
      n = 0;
      do begin
         cycle(); n++;
         any_pend = 0;
         for (int k = 0; k < N; k++) if (pend[k]) any_pend = 1;
         if (n > 2000) begin chk("idle_timeout", 1, 0); finish_tb(); end
      end while (stage != 0 || any_pend || ev_resp);
   endtask

   task automatic post(input int k, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      pend[k] = 1; p_op[k] = op; p_a[k] = a; p_b[k] = b;
   endtask

   initial begin
      int n;
      checks = 0; failures = 0;
      gen_pct = 0; lat_fix = -1; mul_stall = 0; resp_stall = 0;
      junk_zero = 0; rand_bp = 0; last_rd = '0; last_rv = '0;
      rst_ni = 1'b0;
      do_reset();

      // Two requesters contending from reset
      gen_pct = 100; n = 0;
      while (glog.size() < 4 && n < 200) begin cycle(); n++; end
      gen_pct = 0;
      run_idle();
      chk("grant_count", glog.size() >= 4, 1);
      if (glog.size() >= 4) begin
         chk("grant_order0", glog[0], 0);
         chk("grant_order1", glog[1], 1);
         chk("grant_order2", glog[2], 0);
         chk("grant_order3", glog[3], 1);
      end

      // Single multiply
      n_mfire = 0; n_dfire = 0;
      post(0, 1'b0, 32'd7, 32'hFFFF_FFFD);
      run_idle();
      chk("mul_result", last_rd, 32'hFFFF_FFEB);
      chk("mul_owner", last_rv, 2'b01);
      chk("mul_fires", {n_mfire, n_dfire}, {32'd1, 32'd0});

      // Single divide
      n_mfire = 0; n_dfire = 0;
      post(1, 1'b1, 32'd100, 32'd7);
      run_idle();
      chk("div_result", last_rd, 32'd14);
      chk("div_owner", last_rv, 2'b10);
      chk("div_fires", {n_mfire, n_dfire}, {32'd0, 32'd1});

      // Backpressure on the unit, then on the response, with a second requester waiting
      glog.delete();
      mul_stall = 10; resp_stall = 5;
      post(0, 1'b0, 32'd12, 32'd11);
      post(1, 1'b1, 32'd77, 32'd7);
      n = 0;
      while (resp_stall > 0 && n < 200) begin cycle(); n++; end
      chk("bp_single_grant", glog.size(), 1);
      run_idle();
      chk("bp_grants", glog.size(), 2);
      chk("bp_last_result", last_rd, 32'd11);

      // Operand change after grant
      junk_zero = 1;
      post(0, 1'b0, 32'd6, 32'd5);
      run_idle();
      chk("latched_operands", last_rd, 32'd30);
      junk_zero = 0;

      // Reset while waiting on the divider
      lat_fix = 6;
      post(1, 1'b1, 32'd50, 32'd5);
      n = 0;
      while (!div_busy && n < 50) begin cycle(); n++; end
      chk("reached_wait", div_busy, 1);
      do_reset();
      lat_fix = -1;
      post(0, 1'b0, 32'd9, 32'd9);
      run_idle();
      chk("post_reset_mul", last_rd, 32'd81);
      chk("post_reset_owner", last_rv, 2'b01);

      // Randomized traffic with random backpressure
      rand_bp = 1; gen_pct = 35;
      repeat (1500) cycle();
      gen_pct = 0;
      run_idle();

      finish_tb();
   end

endmodule

`default_nettype wire
